// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, byte-enable
// constants and helpers used by both the responder and its testbench.
package rv32_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   localparam int WAIT_CNT_W = 4;

   localparam logic [3:0] BE_B0 = 4'b0001;
   localparam logic [3:0] BE_B1 = 4'b0010;
   localparam logic [3:0] BE_B2 = 4'b0100;
   localparam logic [3:0] BE_B3 = 4'b1000;
   localparam logic [3:0] BE_H0 = 4'b0011;
   localparam logic [3:0] BE_H1 = 4'b1100;
   localparam logic [3:0] BE_W  = 4'b1111;

   // Only naturally aligned byte, halfword and word lane groups are legal.
   function automatic logic be_is_legal(input logic [3:0] be);
      logic ok;
      case (be)
         BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: ok = 1'b1;
         default:                                         ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [31:0] be_to_mask(input logic [3:0] be);
      return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the core load/store unit (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous byte-lane write, asynchronous read.
// Contents are deliberately not reset.
module dmem_array #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   input  logic [3:0]                     be,
   output logic [31:0]                    rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int k = 0; k < 4; k++) begin
            if (be[k]) mem_q[addr][8*k +: 8] <= wdata[8*k +: 8];
         end
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then performs the byte-masked access and holds the response until taken.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// WAIT  | request latched, counting down wait states
// RESP  | response presented, held until rsp_ready
module dmem_responder
   import rv32_mem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   dmem_state_e           state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [31:0]           addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            be_q, be_d;
   logic                  req_ready_q, req_ready_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [31:0]           rsp_rdata_q, rsp_rdata_d;
   logic                  rsp_err_q, rsp_err_d;

   logic                  access;
   logic                  access_err;
   logic                  arr_we;
   logic [AW-1:0]         word_idx;
   logic [31:0]           arr_rdata;

   // BASE_ADDR is aligned to the array size, so the range check reduces to
   // matching the address bits above the word index.
   always_comb begin
      access_err = (addr_q[1:0] != 2'b00)
                 || !be_is_legal(be_q)
                 || (addr_q[31:AW+2] != BASE_ADDR[31:AW+2]);
      word_idx   = addr_q[AW+1:2];
      access     = (state_q == WAIT) && (cnt_q == '0);
      arr_we     = access && we_q && !access_err;
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk  (clk),
      .we   (arr_we),
      .addr (word_idx),
      .wdata(wdata_q),
      .be   (be_q),
      .rdata(arr_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         IDLE: begin
            if (bus.req_valid && req_ready_q) begin
               we_d    = bus.req_we;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               be_d    = bus.req_be;
               cnt_d   = WAIT_CNT_W'(WAIT_CYCLES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = access_err;
               rsp_rdata_d = (access_err || we_q) ? 32'h0
                                                  : (arr_rdata & be_to_mask(be_q));
               state_d     = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               rsp_rdata_d = 32'h0;
               rsp_err_d   = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         be_q        <= 4'h0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a byte-level memory model predicts each
// response at issue time; a monitor checks data, latency and handshake rules.
module tb_dmem_responder;

   localparam int          DEPTH = 1024;
   localparam int          WAITC = 2;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rst0 = 1'b1;
   always #5 clk = ~clk;

   dmem_responder_if bus ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave));

   dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) dut0 (
      .clk(clk), .reset(rst0), .bus(bus0.slave));

   typedef struct {
      logic [31:0] rd;
      logic        err;
   } exp_t;

   exp_t        sbq[$];
   logic [7:0]  model_mem [DEPTH][4];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          bp_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: byte-addressed memory, legality by set membership.
   task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, output logic [31:0] rd, output logic err);
      longint unsigned a;
      int idx;
      bit legal_be;
      a        = addr;
      legal_be = be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
      err      = (addr % 4 != 0) || !legal_be || a < BASE || a >= longint'(BASE) + 4 * DEPTH;
      rd       = 32'h0;
      if (!err) begin
         idx = int'((a - BASE) / 4);
         for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
               if (we) model_mem[idx][k] = wdata[8*k +: 8];
               else    rd[8*k +: 8]     = model_mem[idx][k];
            end
         end
      end
   endtask

   task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input bit track);
      exp_t e;
      int guard;
      guard = 0;
      @(posedge clk); #1;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_be    = be;
      forever begin
         @(negedge clk);
         if (bus.req_ready) break;
         guard++;
         if (guard > 200) begin
            chk("req_ready_timeout", 32'h0, 32'h1);
            break;
         end
      end
      if (track && guard <= 200) begin
         model_access(we, addr, wdata, be, e.rd, e.err);
         sbq.push_back(e);
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_we    = $urandom_range(0, 1);
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      bus.req_be    = 4'($urandom);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while ((sbq.size() != 0 || bus.rsp_valid) && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 500) chk("drain_timeout", 32'($unsigned(sbq.size())), 32'h0);
   endtask

   always @(posedge clk) begin
      #1;
      if (bp_mode == 1)      bus.rsp_ready = 1'($urandom_range(0, 1));
      else if (bp_mode == 0) bus.rsp_ready = 1'b1;
   end

   // Monitor: latency, hold-under-backpressure, ready rules and scoreboard pops.
   int          acc_cyc = -1;
   bit          prev_hold = 0;
   bit          prev_hs = 0;
   logic [31:0] prev_rd;
   logic        prev_err;

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         acc_cyc   = -1;
         prev_hold = 0;
         prev_hs   = 0;
      end else begin
         if (prev_hs) chk("req_ready_after_hs", bus.req_ready, 32'h1);
         if (bus.rsp_valid) begin
            chk("req_ready_in_resp", bus.req_ready, 32'h0);
            if (prev_hold) begin
               chk("hold_rdata", bus.rsp_rdata, prev_rd);
               chk("hold_err", bus.rsp_err, prev_err);
            end else if (acc_cyc >= 0) begin
               chk("latency", cyc - acc_cyc, WAITC + 1);
            end
            if (bus.rsp_ready) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_rsp", 32'h1, 32'h0);
               end else begin
                  e = sbq.pop_front();
                  chk("rsp_rdata", bus.rsp_rdata, e.rd);
                  chk("rsp_err", bus.rsp_err, e.err);
               end
            end
         end
         if (bus.req_valid && bus.req_ready) acc_cyc = cyc + 1;
         prev_hold = bus.rsp_valid && !bus.rsp_ready;
         prev_hs   = bus.rsp_valid && bus.rsp_ready;
         prev_rd   = bus.rsp_rdata;
         prev_err  = bus.rsp_err;
      end
   end

   initial begin
      int guard;
      logic [31:0] a;
      logic [3:0]  b;
      logic [3:0]  legal_set [7];
      legal_set = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.req_be     = 4'h0;
      bus.rsp_ready  = 1'b1;
      bus0.req_valid = 1'b0;
      bus0.req_we    = 1'b0;
      bus0.req_addr  = 32'h0;
      bus0.req_wdata = 32'h0;
      bus0.req_be    = 4'h0;
      bus0.rsp_ready = 1'b1;

      // Reset values while reset is high, then req_ready one cycle after release.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 32'h0);
      chk("rst_rsp_valid", bus.rsp_valid, 32'h0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_rsp_err", bus.rsp_err, 32'h0);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready_held", bus.req_ready, 32'h0);
      @(negedge clk);
      chk("post_rst_req_ready", bus.req_ready, 32'h1);

      // Give the first 64 words known contents so random loads are predictable.
      for (int i = 0; i < 64; i++) issue(1'b1, BASE + 32'(4 * i), $urandom, 4'b1111, 1'b1);
      drain();

      // Word store/load, then byte merge and halfword read.
      issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 4'b1111, 1'b1);
      issue(1'b1, 32'h10, 32'h00AA0000, 4'b0100, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 4'b1111, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 4'b0011, 1'b1);

      // Faulting stores leave the targeted words untouched.
      issue(1'b1, 32'h12, 32'h11111111, 4'b1111, 1'b1);
      issue(1'b1, 32'h10, 32'h22222222, 4'b0110, 1'b1);
      issue(1'b1, 32'h10, 32'h33333333, 4'b0000, 1'b1);
      issue(1'b1, 32'(4 * DEPTH), 32'h44444444, 4'b1111, 1'b1);
      issue(1'b0, 32'(4 * DEPTH), 32'h0, 4'b1111, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 4'b1111, 1'b1);
      issue(1'b0, 32'h0, 32'h0, 4'b1111, 1'b1);
      drain();

      // Backpressure: response must hold while rsp_ready is low.
      bp_mode = 2;
      @(posedge clk); #1; bus.rsp_ready = 1'b0;
      issue(1'b0, 32'h10, 32'h0, 4'b1111, 1'b1);
      guard = 0;
      while (!bus.rsp_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("bp_rsp_seen", bus.rsp_valid, 32'h1);
      repeat (5) begin
         @(negedge clk);
         chk("bp_req_ready", bus.req_ready, 32'h0);
         chk("bp_rsp_valid", bus.rsp_valid, 32'h1);
      end
      @(posedge clk); #1; bus.rsp_ready = 1'b1; bp_mode = 0;
      drain();

      // Reset during WAIT of a store: no response, no write.
      issue(1'b1, 32'h20, 32'h0, 4'b1111, 1'b1);
      drain();
      issue(1'b1, 32'h20, 32'h12345678, 4'b1111, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_rsp_valid", bus.rsp_valid, 32'h0);
      chk("abort_req_ready", bus.req_ready, 32'h0);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("abort_req_ready_after", bus.req_ready, 32'h1);
      chk("abort_rsp_valid_after", bus.rsp_valid, 32'h0);
      issue(1'b0, 32'h20, 32'h0, 4'b1111, 1'b1);
      drain();

      // Randomised traffic with random backpressure.
      bp_mode = 1;
      for (int i = 0; i < 250; i++) begin
         a = BASE + 32'(4 * $urandom_range(0, 63));
         case ($urandom_range(0, 9))
            0: a = a | 32'($urandom_range(1, 3));
            1: a = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
            default: ;
         endcase
         b = ($urandom_range(0, 7) == 0) ? 4'($urandom) : legal_set[$urandom_range(0, 6)];
         issue(1'($urandom_range(0, 1)), a, $urandom, b, 1'b1);
      end
      bp_mode = 0;
      drain();
      chk("sb_empty", 32'($unsigned(sbq.size())), 32'h0);

      // Zero-wait build: 1-cycle latency, req_ready 1,0,0 repeating.
      @(posedge clk); #1;
      rst0           = 1'b0;
      bus0.req_valid = 1'b1;
      bus0.req_we    = 1'b1;
      bus0.req_addr  = 32'h40;
      bus0.req_wdata = 32'hC0FFEE11;
      bus0.req_be    = 4'b1111;
      @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("w0_req_ready", bus0.req_ready, 32'((i % 3) == 0));
         chk("w0_rsp_valid", bus0.rsp_valid, 32'((i % 3) == 2));
         if (i % 3 == 2) chk("w0_rdata", bus0.rsp_rdata, (i == 2) ? 32'h0 : 32'hC0FFEE11);
         if (i == 0) begin
            @(posedge clk); #1;
            bus0.req_we = 1'b0;
            @(negedge clk);
            chk("w0_req_ready", bus0.req_ready, 32'h0);
            chk("w0_rsp_valid", bus0.rsp_valid, 32'h0);
            i++;
         end
      end
      bus0.req_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Memory-side responder for the core's data-memory port, upgraded from a zero-latency array to a valid/ready request/response handshake. It accepts one load/store request at a time and inserts a parameterised number of wait states. It performs byte-lane-masked reads and writes on an internal word array and returns read data or an error flag. It sits between the core's load/store unit and the data array, letting the core be tested against realistic memory latency.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array (power of two, ≥4)
WAIT_CYCLES, 2, extra cycles between request accept and response (0..15)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (aligned to 4*DEPTH_WORDS)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  responder can accept a request
req_we  in  1  1=store, 0=load
req_addr  in  32  byte address; bits [1:0] must be 0
req_wdata  in  32  store data, lane-aligned (byte k on bits 8k+7:8k)
req_be  in  4  byte-lane enables
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_rdata  out  32  load data; disabled lanes read as zero; 0 for stores and errors
rsp_err  out  1  access fault

Behaviour:
- Clock is clk; reset is reset, synchronous, active-high.
- Reset values: req_ready=0 while reset is high, then 1 in the first cycle after reset deasserts; rsp_valid=0; rsp_rdata=0; rsp_err=0; state=IDLE; counter=0. Array contents are not reset.
- FSM states are IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&req_ready (accept edge E0):
  - latch we/addr/wdata/be;
  - load cnt=WAIT_CYCLES;
  - go to WAIT.
- WAIT: req_ready=0.
  - cnt≠0: decrement.
  - cnt==0: at the next edge perform the access, drive rsp_*, and go to RESP.
  - The access edge is E0+WAIT_CYCLES+1, so rsp_valid is first high WAIT_CYCLES+1 cycles after accept. With WAIT_CYCLES=0 the latency is 1 cycle.
- RESP: rsp_valid=1, and rsp_rdata/rsp_err stay stable until rsp_valid&rsp_ready. On that edge: rsp_valid←0, rsp_rdata←0, rsp_err←0, go to IDLE.
- No same-cycle re-accept. After a response handshake, the next request can be accepted one cycle later at the earliest.
- Exactly one request is outstanding at a time. req_* is ignored outside IDLE.
- Legal req_be values are 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Error conditions:
  - req_addr[1:0]≠0;
  - req_be not legal (including 0000);
  - address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - On error: no array write; rsp_err=1; rsp_rdata=0. Latency is unchanged.
- Word index = (addr−BASE_ADDR)>>2, using the low log2(DEPTH_WORDS) bits after the range check.
- Store: write only the enabled lanes at the access edge. rsp_rdata=0.
- Load: rsp_rdata = array word masked by be. Reads return the value as of the access edge, including earlier completed stores.
- Reset mid-operation (WAIT or RESP): abort with no response.
  - A store still in WAIT does not write.
  - A store already in RESP has already written.
- rsp_ready held high in IDLE/WAIT has no effect.

Decomposition:
- Shared package rv32_mem_pkg holds:
  - FSM state encodings (IDLE/WAIT/RESP);
  - legal byte-enable constants (BE_B0..BE_B3, BE_H0, BE_H1, BE_W);
  - a legal-BE check function;
  - the width constant for the wait counter.
- One sub-module, dmem_array: single-port synchronous-write word array with 4 byte-write enables and asynchronous read. It is parameterised by DEPTH_WORDS.

Test Plan:
1. WAIT_CYCLES=2: store addr=0x10, be=1111, wdata=0xDEADBEEF, then load 0x10 be=1111. Required: each rsp_valid rises exactly 3 cycles after its accept; load rdata=0xDEADBEEF, err=0.
2. Store be=0100, wdata=0x00AA0000 to 0x10 after test 1, then load be=1111. Required: rdata=0xDEAABEEF; load be=0011 returns 0x0000BEEF.
3. Backpressure: load with rsp_ready held low for 5 cycles. Required: rsp_valid, rsp_rdata and rsp_err stay constant and req_ready=0 throughout. After rsp_ready=1 and the handshake, req_ready=1 the following cycle.
4. Errors: addr=0x12, be=1111 → err=1, rdata=0. be=0110 → err=1. addr=4*DEPTH_WORDS → err=1. In every case a subsequent load of the targeted word shows it unchanged.
5. WAIT_CYCLES=0 build: back-to-back loads with rsp_ready tied high. Required: 1-cycle latency, one transaction every 3 cycles, req_ready pattern 1,0,0 repeating.
6. Assert reset during WAIT of a store of 0x12345678 to 0x20 (prior value 0x0). Required: after reset rsp_valid=0 and req_ready=1; a load of 0x20 returns 0x00000000.
